// File: rtl/spike_frame_sequencer.sv
// spike_frame_sequencer: per-frame initiator for a neuron's synaptic
// read/accumulate interface (clear, address scan, update strobe, done).
module spike_frame_sequencer #(
    parameter  int FANIN           = 256,
    parameter  int SKIP_SILENT     = 0,
    parameter  int FRAME_CNT_WIDTH = 16,
    localparam int ADDR_WIDTH      = (FANIN > 1) ? $clog2(FANIN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [FANIN-1:0]           spk_vec,
    output logic                       rst_acc,
    output logic                       rd_en,
    output logic [ADDR_WIDTH-1:0]      rd_addr,
    output logic                       inspk,
    output logic                       spk_tick,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_FIRE,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FANIN - 1);

    state_t                       r_state;
    logic [FANIN-1:0]             r_vec;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic                         r_rst_acc;
    logic                         r_rd_en;
    logic                         r_inspk;
    logic                         r_spk_tick;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_overrun;
    logic [FRAME_CNT_WIDTH-1:0]   r_frame_cnt;

    state_t                       w_state_nxt;
    logic [ADDR_WIDTH-1:0]        w_addr_nxt;
    logic                         w_first_hit;
    logic [ADDR_WIDTH-1:0]        w_first_idx;
    logic                         w_next_hit;
    logic [ADDR_WIDTH-1:0]        w_next_idx;
    logic                         w_rst_acc_nxt;
    logic                         w_rd_en_nxt;
    logic                         w_inspk_nxt;
    logic                         w_spk_tick_nxt;
    logic                         w_busy_nxt;
    logic                         w_done_nxt;

    // Priority search of the latched vector: lowest set bit overall and
    // lowest set bit strictly above the current scan address.
    always_comb begin
        w_first_hit = 1'b0;
        w_first_idx = '0;
        w_next_hit  = 1'b0;
        w_next_idx  = '0;
        for (int i = FANIN - 1; i >= 0; i--) begin
            if (r_vec[i]) begin
                w_first_hit = 1'b1;
                w_first_idx = ADDR_WIDTH'(i);
            end
            if (r_vec[i] && (i > int'(r_addr))) begin
                w_next_hit = 1'b1;
                w_next_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Next-state and next scan address.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (SKIP_SILENT != 0) begin
                    if (w_first_hit) begin
                        w_state_nxt = S_SCAN;
                        w_addr_nxt  = w_first_idx;
                    end else begin
                        w_state_nxt = S_FIRE;
                    end
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (SKIP_SILENT != 0) begin
                    if (w_next_hit) begin
                        w_addr_nxt = w_next_idx;
                    end else begin
                        w_state_nxt = S_FIRE;
                    end
                end else if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_FIRE;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            S_FIRE:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming state, registered below.
    always_comb begin
        w_rst_acc_nxt  = 1'b0;
        w_rd_en_nxt    = 1'b0;
        w_inspk_nxt    = 1'b0;
        w_spk_tick_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        unique case (w_state_nxt)
            S_CLEAR: begin
                w_rst_acc_nxt = 1'b1;
                w_busy_nxt    = 1'b1;
            end
            S_SCAN: begin
                w_rd_en_nxt = 1'b1;
                w_inspk_nxt = r_vec[w_addr_nxt];
                w_busy_nxt  = 1'b1;
            end
            S_FIRE: begin
                w_spk_tick_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // State, latched vector, registered outputs, counters and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_addr      <= '0;
            r_rst_acc   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_inspk     <= 1'b0;
            r_spk_tick  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_rst_acc  <= w_rst_acc_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_inspk    <= w_inspk_nxt;
            r_spk_tick <= w_spk_tick_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (r_state == S_IDLE && start) begin
                r_vec <= spk_vec;
            end
            if (r_state != S_IDLE && start) begin
                r_overrun <= 1'b1;
            end
            if (w_state_nxt == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    assign rst_acc   = r_rst_acc;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_addr;
    assign inspk     = r_inspk;
    assign spk_tick  = r_spk_tick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spike_frame_sequencer.sv
// tb_spike_frame_sequencer: three DUT configurations driven by shared
// stimulus, checked every cycle against a frame-level timeline model.
module tb_spike_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] spk_vec;

    logic       a_rst_acc, a_rd_en, a_inspk, a_spk_tick, a_busy, a_done, a_overrun;
    logic [2:0] a_rd_addr;
    logic [15:0] a_frame_cnt;
    logic       b_rst_acc, b_rd_en, b_inspk, b_spk_tick, b_busy, b_done, b_overrun;
    logic [2:0] b_rd_addr;
    logic [15:0] b_frame_cnt;
    logic       c_rst_acc, c_rd_en, c_inspk, c_spk_tick, c_busy, c_done, c_overrun;
    logic [2:0] c_rd_addr;
    logic [1:0] c_frame_cnt;

    spike_frame_sequencer #(.FANIN(8), .SKIP_SILENT(0), .FRAME_CNT_WIDTH(16)) u0 (
        .clk(clk), .rst(rst), .start(start), .spk_vec(spk_vec),
        .rst_acc(a_rst_acc), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .inspk(a_inspk), .spk_tick(a_spk_tick), .busy(a_busy),
        .done(a_done), .overrun(a_overrun), .frame_cnt(a_frame_cnt)
    );

    spike_frame_sequencer #(.FANIN(8), .SKIP_SILENT(1), .FRAME_CNT_WIDTH(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .spk_vec(spk_vec),
        .rst_acc(b_rst_acc), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .inspk(b_inspk), .spk_tick(b_spk_tick), .busy(b_busy),
        .done(b_done), .overrun(b_overrun), .frame_cnt(b_frame_cnt)
    );

    spike_frame_sequencer #(.FANIN(8), .SKIP_SILENT(0), .FRAME_CNT_WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .spk_vec(spk_vec),
        .rst_acc(c_rst_acc), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
        .inspk(c_inspk), .spk_tick(c_spk_tick), .busy(c_busy),
        .done(c_done), .overrun(c_overrun), .frame_cnt(c_frame_cnt)
    );

    // One expected output cycle; active marks any non-idle cycle.
    typedef struct packed {
        logic       rst_acc;
        logic       rd_en;
        logic [2:0] addr;
        logic       inspk;
        logic       tick;
        logic       busy;
        logic       done;
        logic       active;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t cur_a;
    exp_t cur_b;
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   ov_a = 1'b0;
    bit   ov_b = 1'b0;
    bit   mvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(bit ra, bit re, int ad, bit is, bit tk, bit bz, bit dn);
        exp_t e;
        e.rst_acc = ra;
        e.rd_en   = re;
        e.addr    = 3'(ad);
        e.inspk   = is;
        e.tick    = tk;
        e.busy    = bz;
        e.done    = dn;
        e.active  = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] pk(exp_t e);
        return 32'({e.rst_acc, e.rd_en, e.addr, e.inspk, e.tick, e.busy, e.done});
    endfunction

    // Whole-frame timeline: clear, visited addresses, fire, done.
    task automatic build(input bit skip, input logic [7:0] v);
        exp_t fr[$];
        fr.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 8; k++) begin
            if (!skip || v[k]) fr.push_back(mk(0, 1, k, v[k], 0, 1, 0));
        end
        fr.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        fr.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        foreach (fr[i]) begin
            if (skip) qb.push_back(fr[i]);
            else qa.push_back(fr[i]);
        end
    endtask

    // Reference model advances once per clock edge.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            cur_a = '0;
            cur_b = '0;
            cnt_a = 0;
            cnt_b = 0;
            ov_a = 1'b0;
            ov_b = 1'b0;
            mvalid = 1'b1;
        end else begin
            if (start) begin
                if (cur_a.active) ov_a = 1'b1;
                else build(1'b0, spk_vec);
                if (cur_b.active) ov_b = 1'b1;
                else build(1'b1, spk_vec);
            end
            if (qa.size() > 0) cur_a = qa.pop_front();
            else cur_a = '0;
            if (qb.size() > 0) cur_b = qb.pop_front();
            else cur_b = '0;
            if (cur_a.done) cnt_a++;
            if (cur_b.done) cnt_b++;
        end
    end

    // Per-cycle comparison of all three DUTs against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("u0_out", 32'({a_rst_acc, a_rd_en, a_rd_addr, a_inspk, a_spk_tick, a_busy, a_done}), pk(cur_a));
            chk("u0_cnt", 32'(a_frame_cnt), 32'(cnt_a % 65536));
            chk("u0_ovr", 32'(a_overrun), 32'(ov_a));
            chk("u1_out", 32'({b_rst_acc, b_rd_en, b_rd_addr, b_inspk, b_spk_tick, b_busy, b_done}), pk(cur_b));
            chk("u1_cnt", 32'(b_frame_cnt), 32'(cnt_b % 65536));
            chk("u1_ovr", 32'(b_overrun), 32'(ov_b));
            chk("u2_out", 32'({c_rst_acc, c_rd_en, c_rd_addr, c_inspk, c_spk_tick, c_busy, c_done}), pk(cur_a));
            chk("u2_cnt", 32'(c_frame_cnt), 32'(cnt_a % 4));
            chk("u2_ovr", 32'(c_overrun), 32'(ov_a));
        end
    end

    logic [7:0] seq;
    int wl[5];

    initial begin
        rst = 1'b1;
        start = 1'b0;
        spk_vec = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy", 32'(a_busy | b_busy | c_busy), 32'd0);
            chk("idle_cnt", 32'(a_frame_cnt), 32'd0);
        end

        // full scan, SKIP_SILENT=0
        seq = 8'b1010_0110;
        spk_vec = 8'b1010_0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("full_rst_acc", 32'(a_rst_acc), 32'd1);
        chk("full_c1_rd_en", 32'(a_rd_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("full_addr", 32'(a_rd_addr), 32'(k));
            chk("full_rd_en", 32'(a_rd_en), 32'd1);
            chk("full_inspk", 32'(a_inspk), 32'(seq[k]));
        end
        @(negedge clk);
        chk("full_tick", 32'(a_spk_tick), 32'd1);
        chk("full_tick_rd_en", 32'(a_rd_en), 32'd0);
        @(negedge clk);
        chk("full_done", 32'(a_done), 32'd1);
        chk("full_done_busy", 32'(a_busy), 32'd0);
        chk("full_cnt", 32'(a_frame_cnt), 32'd1);
        @(negedge clk);
        chk("full_done_pulse", 32'(a_done), 32'd0);

        // sparse scan, SKIP_SILENT=1
        spk_vec = 8'b1000_0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sparse_rst_acc", 32'(b_rst_acc), 32'd1);
        @(negedge clk);
        chk("sparse_addr2", 32'({b_rd_en, b_rd_addr, b_inspk}), 32'b1_010_1);
        @(negedge clk);
        chk("sparse_addr7", 32'({b_rd_en, b_rd_addr, b_inspk}), 32'b1_111_1);
        @(negedge clk);
        chk("sparse_tick", 32'({b_spk_tick, b_rd_en}), 32'b10);
        @(negedge clk);
        chk("sparse_done", 32'(b_done), 32'd1);
        repeat (7) @(negedge clk);

        // all-zero vector, SKIP_SILENT=1
        spk_vec = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_clear", 32'({b_rst_acc, b_rd_en}), 32'b10);
        @(negedge clk);
        chk("zero_tick", 32'({b_spk_tick, b_rd_en}), 32'b10);
        @(negedge clk);
        chk("zero_done", 32'({b_done, b_rd_en}), 32'b10);
        repeat (9) @(negedge clk);

        // overrun and vector isolation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ovr_cleared", 32'(a_overrun), 32'd0);
        spk_vec = 8'hA5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        spk_vec = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ovr_set", 32'(a_overrun), 32'd1);
        repeat (2) @(negedge clk);
        chk("ovr_iso_inspk5", 32'({a_rd_addr, a_inspk}), 32'b101_1);
        repeat (4) @(negedge clk);
        chk("ovr_done", 32'(a_done), 32'd1);
        chk("ovr_cnt", 32'(a_frame_cnt), 32'd1);
        chk("ovr_sticky", 32'(a_overrun), 32'd1);
        @(negedge clk);

        // mid-frame reset
        spk_vec = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out", 32'({a_busy, a_rd_en, a_rd_addr, a_inspk, a_overrun}), 32'd0);
        chk("mid_rst_cnt", 32'(a_frame_cnt), 32'd0);
        repeat (10) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(a_done), 32'd0);
        end

        // counter wrap on the 2-bit instance, frames back-to-back
        wl = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            spk_vec = 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (10) @(negedge clk);
            chk("wrap_done", 32'(c_done), 32'd1);
            chk("wrap_cnt", 32'(c_frame_cnt), 32'(wl[i]));
            @(negedge clk);
        end
        chk("wrap_no_ovr", 32'(c_overrun), 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) spk_vec = 8'($urandom);
            else spk_vec = 8'($urandom & $urandom & $urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
